// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and sequencer state encoding.
package kyber_pkg;

  localparam int KYBER_N = 256;

  typedef logic signed [15:0] coeff_t;

  localparam coeff_t KYBER_Q = 16'sd3329;
  localparam coeff_t QINV    = -16'sd3327;
  localparam coeff_t MONT_R2 = 16'sd1353;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fqmul.sv
// Combinational Kyber Montgomery multiply: c = a*b*2^-16 mod q, result in (-q,q).
module fqmul
  import kyber_pkg::*;
(
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t c_o
);

  logic signed [31:0] p_s;
  logic signed [31:0] tq_s;
  logic        [15:0] t_lo_s;
  coeff_t             t_s;

  // Montgomery reduction; the low half of p - t*q is zero by construction
  always_comb begin
    p_s    = 32'(a_i) * 32'(b_i);
    t_lo_s = 16'(p_s[15:0] * QINV);
    t_s    = coeff_t'(t_lo_s);
    tq_s   = 32'(t_s) * 32'(KYBER_Q);
    c_o    = coeff_t'(16'((p_s - tq_s) >>> 16));
  end

endmodule

// File: rtl/fqmul_poly_seq.sv
// Walks N coefficient indices, reads a/b from 1-cycle RAMs, multiplies via fqmul and
// streams results through a 2-entry output FIFO with full valid/ready backpressure.
module fqmul_poly_seq
  import kyber_pkg::*;
#(
  parameter int N  = KYBER_N,
  parameter int AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          mode_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  coeff_t        a_rdata_i,
  input  coeff_t        b_rdata_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output coeff_t        res_data_o,
  output logic [AW-1:0] res_idx_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  seq_state_e    state_q;
  logic          busy_q, done_q, mode_q;
  logic [AW-1:0] idx_q;
  logic          dv_q;
  logic [AW-1:0] dv_idx_q;

  logic          head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  coeff_t        head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [AW-1:0] head_idx_q, head_idx_d, skid_idx_q, skid_idx_d;

  logic          pop_s, push_s, issue_s;
  logic [1:0]    occ_s;
  coeff_t        b_op_s, c_s;

  // Occupancy counts reads whose data is arriving now plus queued results, less this cycle's pop
  always_comb begin
    pop_s   = head_vld_q & res_ready_i;
    push_s  = dv_q;
    occ_s   = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, dv_q} - {1'b0, pop_s};
    issue_s = (state_q == RUN) && (occ_s < 2'd2);
  end

  // Operand select: conversion mode multiplies by R^2 mod q
  always_comb begin
    if (mode_q) begin
      b_op_s = MONT_R2;
    end else begin
      b_op_s = b_rdata_i;
    end
  end

  fqmul u_fqmul (
    .a_i (a_rdata_i),
    .b_i (b_op_s),
    .c_o (c_s)
  );

  // Sequencer FSM, read index and read-data-valid pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      dv_q     <= 1'b0;
      dv_idx_q <= '0;
    end else begin
      dv_q     <= issue_s;
      dv_idx_q <= idx_q;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            mode_q  <= mode_i;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (issue_s) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop_s && (head_idx_q == LAST_IDX)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry FIFO: head drives the port, skid absorbs one result while the head stalls
  always_comb begin
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    head_idx_d  = head_idx_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    if (!head_vld_q || pop_s) begin
      if (skid_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = skid_data_q;
        head_idx_d  = skid_idx_q;
        skid_vld_d  = push_s;
        skid_data_d = c_s;
        skid_idx_d  = dv_idx_q;
      end else if (push_s) begin
        head_vld_d  = 1'b1;
        head_data_d = c_s;
        head_idx_d  = dv_idx_q;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push_s) begin
      skid_vld_d  = 1'b1;
      skid_data_d = c_s;
      skid_idx_d  = dv_idx_q;
    end else begin
      skid_vld_d = skid_vld_q;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_idx_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      head_idx_q  <= head_idx_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = issue_s;
  assign rd_addr_o   = idx_q;
  assign res_valid_o = head_vld_q;
  assign res_data_o  = head_data_q;
  assign res_idx_o   = head_idx_q;

endmodule
